// File: rtl/hdmi_pattern_gen_if.sv
// Control inputs and registered video outputs of the HDMI test-pattern source.
// The stream has no backpressure: de qualifies each pixel, and the sink must take one pixel on every clk_low edge.
interface hdmi_pattern_gen_if #(
    parameter int CNT_W = 12
);
    logic             enable;
    logic [2:0]       mode;
    logic [23:0]      solid_rgb;
    logic [7:0]       red;
    logic [7:0]       green;
    logic [7:0]       blue;
    logic             hsync;
    logic             vsync;
    logic             de;
    logic             frame_start;
    logic [CNT_W-1:0] x;
    logic [CNT_W-1:0] y;
    logic [7:0]       frame_count;

    // The pattern generator sources the video stream.
    modport master (
        input  enable, mode, solid_rgb,
        output red, green, blue, hsync, vsync, de, frame_start, x, y, frame_count
    );

    // The controller and video sink side.
    modport slave (
        output enable, mode, solid_rgb,
        input  red, green, blue, hsync, vsync, de, frame_start, x, y, frame_count
    );
endinterface

// File: rtl/hdmi_pattern_gen.sv
// Parametrised video timing and test-pattern source for the TMDS transmitter.
// All outputs are registered from the current h/v counters on the edge that advances them.
module hdmi_pattern_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit HSYNC_POL  = 1'b0,
    parameter bit VSYNC_POL  = 1'b0,
    parameter int CNT_W      = 12,
    parameter int CHECK_LOG2 = 5
) (
    input  logic               clk_low,
    input  logic               reset,
    hdmi_pattern_gen_if.master vid
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = H_ACTIVE / 8;

    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT      = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT      = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] HS_START   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] BAR_LAST   = CNT_W'(BAR_W - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic [CNT_W-1:0] bar_px;
    logic [2:0]       bar_idx;
    logic [2:0]       mode_q;
    logic [2:0]       cur_mode;
    logic             frame_origin;
    logic             active;
    logic             in_hsync;
    logic             in_vsync;
    logic             on_border;
    logic [23:0]      bar_rgb;
    logic [23:0]      pat_rgb;

    always_comb begin
        frame_origin = (h_cnt == '0) && (v_cnt == '0);
        // Pixel (0,0) already uses the mode being latched on this edge.
        cur_mode  = frame_origin ? vid.mode : mode_q;
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        in_hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
        in_vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
        on_border = (h_cnt == '0) || (h_cnt == H_ACT_LAST) ||
                    (v_cnt == '0) || (v_cnt == V_ACT_LAST);
        // White..black bar order makes each channel a single inverted index bit.
        bar_rgb = {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        pat_rgb = '0;
        case (cur_mode)
            3'd0:    pat_rgb = vid.solid_rgb;
            3'd1:    pat_rgb = bar_rgb;
            3'd2:    pat_rgb = (h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]) ? 24'hFFFFFF : 24'h000000;
            3'd3:    pat_rgb = {3{h_cnt[7:0]}};
            3'd4:    pat_rgb = {v_cnt[7:0], 16'h0000};
            3'd5:    pat_rgb = on_border ? 24'hFFFFFF : 24'h000000;
            default: pat_rgb = '0;
        endcase
        if (!active) begin
            pat_rgb = '0;
        end
    end

    always_ff @(posedge clk_low) begin
        if (reset || !vid.enable) begin
            h_cnt           <= '0;
            v_cnt           <= '0;
            bar_px          <= '0;
            bar_idx         <= '0;
            mode_q          <= '0;
            vid.red         <= '0;
            vid.green       <= '0;
            vid.blue        <= '0;
            vid.hsync       <= ~HSYNC_POL;
            vid.vsync       <= ~VSYNC_POL;
            vid.de          <= 1'b0;
            vid.frame_start <= 1'b0;
            vid.x           <= '0;
            vid.y           <= '0;
            if (reset) begin
                vid.frame_count <= '0;
            end
        end else begin
            vid.red         <= pat_rgb[23:16];
            vid.green       <= pat_rgb[15:8];
            vid.blue        <= pat_rgb[7:0];
            vid.hsync       <= in_hsync ? HSYNC_POL : ~HSYNC_POL;
            vid.vsync       <= in_vsync ? VSYNC_POL : ~VSYNC_POL;
            vid.de          <= active;
            vid.frame_start <= frame_origin;
            vid.x           <= h_cnt;
            vid.y           <= v_cnt;
            if (frame_origin) begin
                mode_q          <= vid.mode;
                vid.frame_count <= vid.frame_count + 8'd1;
            end

            // The bar position tracks h_cnt, so it restarts whenever the line does.
            if (h_cnt == H_LAST) begin
                h_cnt   <= '0;
                v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + ONE;
                bar_px  <= '0;
                bar_idx <= '0;
            end else begin
                h_cnt <= h_cnt + ONE;
                if (bar_px == BAR_LAST) begin
                    bar_px <= '0;
                    if (bar_idx != 3'd7) begin
                        bar_idx <= bar_idx + 3'd1;
                    end
                end else begin
                    bar_px <= bar_px + ONE;
                end
            end
        end
    end
endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Self-checking bench for hdmi_pattern_gen on a small 24x8 raster (16x4 active).
// A frame-position model predicts every output cycle; directed checks pin known pixels.
module tb_hdmi_pattern_gen;
    localparam int H_ACT = 16;
    localparam int H_FP  = 2;
    localparam int H_SY  = 3;
    localparam int H_BP  = 3;
    localparam int V_ACT = 4;
    localparam int V_FP  = 1;
    localparam int V_SY  = 2;
    localparam int V_BP  = 1;
    localparam int CHK   = 1;
    localparam int H_TOT = H_ACT + H_FP + H_SY + H_BP;
    localparam int V_TOT = V_ACT + V_FP + V_SY + V_BP;
    localparam int FRAME = H_TOT * V_TOT;
    localparam int W     = 60;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    hdmi_pattern_gen_if #(.CNT_W(12)) vid ();

    hdmi_pattern_gen #(
        .H_ACTIVE(H_ACT), .H_FP(H_FP), .H_SYNC(H_SY), .H_BP(H_BP),
        .V_ACTIVE(V_ACT), .V_FP(V_FP), .V_SYNC(V_SY), .V_BP(V_BP),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(12), .CHECK_LOG2(CHK)
    ) dut (
        .clk_low(clk),
        .reset  (reset),
        .vid    (vid)
    );

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           n_cmp  = 0;
    int           n_fail = 0;
    int           m_p    = 0;
    int           m_fc   = 0;
    logic [2:0]   m_mode = 3'd0;
    logic [23:0]  bars_lit [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [23:0] bar_colour(input int b);
        case (b)
            0: return 24'hFFFFFF;
            1: return 24'hFFFF00;
            2: return 24'h00FFFF;
            3: return 24'h00FF00;
            4: return 24'hFF00FF;
            5: return 24'hFF0000;
            6: return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    function automatic logic [23:0] pattern(input int xx, input int yy, input logic [2:0] md,
                                            input logic [23:0] solid);
        int b;
        if (!(xx < H_ACT && yy < V_ACT)) return 24'h0;
        case (md)
            3'd0: return solid;
            3'd1: begin
                b = xx / (H_ACT / 8);
                if (b > 7) b = 7;
                return bar_colour(b);
            end
            3'd2: return ((((xx >> CHK) ^ (yy >> CHK)) & 1) != 0) ? 24'hFFFFFF : 24'h0;
            3'd3: return {3{8'(xx % 256)}};
            3'd4: return {8'(yy % 256), 16'h0};
            3'd5: return (xx == 0 || xx == H_ACT - 1 || yy == 0 || yy == V_ACT - 1) ? 24'hFFFFFF : 24'h0;
            default: return 24'h0;
        endcase
    endfunction

    function automatic logic [W-1:0] pixel_vec(input int xx, input int yy, input logic [2:0] md,
                                                input logic [23:0] solid, input int fc, input bit fs);
        bit act = (xx < H_ACT) && (yy < V_ACT);
        bit hs  = !((xx >= H_ACT + H_FP) && (xx < H_ACT + H_FP + H_SY));
        bit vs  = !((yy >= V_ACT + V_FP) && (yy < V_ACT + V_FP + V_SY));
        return {pattern(xx, yy, md, solid), hs, vs, act, fs, 12'(xx), 12'(yy), 8'(fc)};
    endfunction

    function automatic logic [W-1:0] blank_vec(input int fc);
        return {24'h0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h0, 12'h0, 8'(fc)};
    endfunction

    function automatic logic [W-1:0] dut_vec();
        return {vid.red, vid.green, vid.blue, vid.hsync, vid.vsync, vid.de, vid.frame_start,
                vid.x, vid.y, vid.frame_count};
    endfunction

    initial forever begin : model
        @(posedge clk);
        if (reset) begin
            m_p = 0;
            m_fc = 0;
            m_mode = 3'd0;
            exp_q.push_back(blank_vec(0));
        end else if (!vid.enable) begin
            m_p = 0;
            exp_q.push_back(blank_vec(m_fc));
        end else begin
            if (m_p == 0) begin
                m_mode = vid.mode;
                m_fc   = (m_fc + 1) % 256;
            end
            exp_q.push_back(pixel_vec(m_p % H_TOT, m_p / H_TOT, m_mode, vid.solid_rgb, m_fc, m_p == 0));
            m_p = (m_p + 1) % FRAME;
        end
    end

    initial forever begin : compare
        @(negedge clk);
        if (exp_q.size() != 0) check("pixel_vec", 64'(dut_vec()), 64'(exp_q.pop_front()));
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: bench did not finish by t=%0t", $time);
        $fatal(1, "bench timeout");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_pixel(input int xx, input int yy);
        int n = 0;
        while (!(int'(vid.x) == xx && int'(vid.y) == yy) && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (n >= 2 * FRAME) check("wait_xy", 64'({vid.x, vid.y}), 64'({12'(xx), 12'(yy)}));
    endtask

    task automatic wait_fs();
        int n = 0;
        do begin
            tick();
            n++;
        end while (vid.frame_start !== 1'b1 && n < FRAME + 4);
        if (vid.frame_start !== 1'b1) check("wait_fs", 64'(vid.frame_start), 64'(1));
    endtask

    task automatic check_rgb(input string name, input logic [23:0] exp);
        check(name, 64'({vid.red, vid.green, vid.blue}), 64'(exp));
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        int n;
        vid.enable    = 1'b1;
        vid.mode      = 3'd1;
        vid.solid_rgb = 24'h000000;
        repeat (3) tick();
        check("rst_de", 64'(vid.de), 64'(0));
        check("rst_hsync", 64'(vid.hsync), 64'(1));
        check("rst_vsync", 64'(vid.vsync), 64'(1));
        check("rst_fc", 64'(vid.frame_count), 64'(0));
        check_rgb("rst_rgb", 24'h0);

        // First line of colour bars.
        reset = 1'b0;
        tick();
        check("first_fs", 64'(vid.frame_start), 64'(1));
        check("first_y", 64'(vid.y), 64'(0));
        check("first_fc", 64'(vid.frame_count), 64'(1));
        for (int i = 0; i < H_TOT; i++) begin
            check("sweep_x", 64'(vid.x), 64'(i));
            check_rgb("bar_rgb", (i < H_ACT) ? bars_lit[i / 2] : 24'h0);
            check("sweep_hsync", 64'(vid.hsync), (i >= 18 && i <= 20) ? 64'(0) : 64'(1));
            check("sweep_de", 64'(vid.de), (i < 16) ? 64'(1) : 64'(0));
            if (i < H_TOT - 1) tick();
        end

        // Frame period.
        wait_fs();
        n = 0;
        do begin
            tick();
            n++;
        end while (vid.frame_start !== 1'b1 && n < 400);
        check("frame_period", 64'(n), 64'(192));

        // Solid colour, mode change mid-frame takes effect next frame.
        vid.mode      = 3'd0;
        vid.solid_rgb = 24'h123456;
        wait_fs();
        wait_pixel(0, 2);
        vid.mode = 3'd2;
        wait_pixel(5, 3);
        check_rgb("solid_hold", 24'h123456);
        wait_fs();
        check_rgb("chk_0_0", 24'h000000);
        wait_pixel(2, 0);
        check_rgb("chk_2_0", 24'hFFFFFF);
        wait_pixel(2, 1);
        check_rgb("chk_2_1", 24'hFFFFFF);
        wait_pixel(2, 2);
        check_rgb("chk_2_2", 24'h000000);

        // 257 frames: frame_count wraps to 1.
        vid.mode = 3'd3;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 257; k++) begin
            wait_fs();
            if (k == 128) vid.mode = 3'd4;
        end
        check("fc_wrap", 64'(vid.frame_count), 64'(1));

        // Reset mid-line.
        wait_pixel(7, 1);
        reset = 1'b1;
        tick();
        check("mid_rst_de", 64'(vid.de), 64'(0));
        check("mid_rst_sync", 64'({vid.hsync, vid.vsync}), 64'(2'b11));
        check("mid_rst_xy", 64'({vid.x, vid.y}), 64'(0));
        check("mid_rst_fs", 64'(vid.frame_start), 64'(0));
        check("mid_rst_fc", 64'(vid.frame_count), 64'(0));
        check_rgb("mid_rst_rgb", 24'h0);
        reset = 1'b0;
        tick();
        check("rel_fs", 64'(vid.frame_start), 64'(1));
        check("rel_xy", 64'({vid.x, vid.y}), 64'(0));
        check("rel_fc", 64'(vid.frame_count), 64'(1));

        // Enable dropped mid-frame for 10 cycles.
        wait_pixel(5, 2);
        vid.enable = 1'b0;
        vid.mode   = 3'd5;
        repeat (10) tick();
        check("dis_de", 64'(vid.de), 64'(0));
        check("dis_sync", 64'({vid.hsync, vid.vsync}), 64'(2'b11));
        check("dis_fc", 64'(vid.frame_count), 64'(1));
        check_rgb("dis_rgb", 24'h0);
        vid.enable = 1'b1;
        tick();
        check("reen_fs", 64'(vid.frame_start), 64'(1));
        check("reen_xy", 64'({vid.x, vid.y}), 64'(0));
        check("reen_fc", 64'(vid.frame_count), 64'(2));

        // Border pattern.
        check_rgb("brd_0_0", 24'hFFFFFF);
        wait_pixel(5, 0);
        check_rgb("brd_5_0", 24'hFFFFFF);
        wait_pixel(15, 1);
        check_rgb("brd_15_1", 24'hFFFFFF);
        wait_pixel(0, 2);
        check_rgb("brd_0_2", 24'hFFFFFF);
        wait_pixel(5, 2);
        check_rgb("brd_5_2", 24'h000000);
        wait_pixel(5, 3);
        check_rgb("brd_5_3", 24'hFFFFFF);

        // Reserved mode: black active video.
        vid.mode = 3'd6;
        wait_fs();
        check_rgb("rsv_0_0", 24'h0);
        check("rsv_de_0_0", 64'(vid.de), 64'(1));
        wait_pixel(3, 1);
        check_rgb("rsv_3_1", 24'h0);
        check("rsv_de_3_1", 64'(vid.de), 64'(1));

        repeat (4) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hdmi_pattern_gen.md
Name: hdmi_pattern_gen

Overview:
- Parametrised video timing and test-pattern source for the HDMI path.
- Successor to the fixed constant-colour stimulus.
- Generates H/V timing, DE and 24-bit RGB on the pixel clock, and feeds red/green/blue plus sync/DE into the TMDS transceiver.
- Runtime-selectable patterns, frame counter and pixel coordinates for board bring-up.

Parameters:
H_ACTIVE, 640, active pixels per line (multiple of 8)
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, active lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HSYNC_POL, 0, hsync asserted level (0 = active-low)
VSYNC_POL, 0, vsync asserted level
CNT_W, 12, width of h/v counters and x/y outputs
CHECK_LOG2, 5, checkerboard square size = 2^CHECK_LOG2 pixels

Ports:
clk_low  in  1  pixel clock
reset  in  1  synchronous, active-high reset
enable  in  1  1 = run timing; 0 = counters held at 0, outputs blanked
mode  in  3  pattern select, sampled only at frame start
solid_rgb  in  24  colour for mode 0, {R,G,B}
red  out  8  pixel red
green  out  8  pixel green
blue  out  8  pixel blue
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  data enable (active video)
frame_start  out  1  one-cycle pulse coincident with pixel (0,0)
x  out  CNT_W  column of current output pixel
y  out  CNT_W  line of current output pixel
frame_count  out  8  frames started since reset, wraps 255->0

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Internal h_cnt runs 0..H_TOTAL-1. v_cnt increments when h_cnt wraps and runs 0..V_TOTAL-1; both wrap to 0 together at the frame end.
- Output timing: all outputs are registered from the current counters on the same edge that advances them, giving 1-cycle latency. The first edge with reset=0 and enable=1 outputs pixel (0,0): de=1, frame_start=1, x=0, y=0.
- de = (h<H_ACTIVE)&&(v<V_ACTIVE).
- hsync = HSYNC_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else ~HSYNC_POL. vsync is analogous on v (whole lines), independent of h.
- x/y equal the h/v counters of the emitted pixel, including in blanking.
- RGB is forced to 0 whenever de=0.
- Mode latching: mode_q loads mode at h=0,v=0, also on the first frame after reset/enable. A mid-frame change of mode never alters the current frame.
- Patterns by mode_q:
  - 0: solid_rgb, sampled live.
  - 1: 8 vertical bars of width BAR_W=H_ACTIVE/8, in order white, yellow, cyan, green, magenta, red, blue, black (full-scale 8'hFF/8'h00). Bar index comes from a bar counter that resets at h=0 and steps every BAR_W pixels, saturating at 7. No divider.
  - 2: checkerboard; white if x[CHECK_LOG2]^y[CHECK_LOG2] else black.
  - 3: horizontal grey ramp, R=G=B=x[7:0] (wraps every 256 px).
  - 4: vertical red ramp, R=y[7:0], G=B=0.
  - 5: white 1-pixel border on x=0, x=H_ACTIVE-1, y=0, y=V_ACTIVE-1; black inside.
  - 6, 7: reserved, output black.
- frame_count increments on the same edge frame_start is driven high.
- Reset (any time, including mid-line): counters=0, mode_q=0, frame_count=0, RGB=0, de=0, frame_start=0, x=y=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL.
- enable=0: counters are forced to 0 and outputs take the reset values, except frame_count, which holds. Re-enable restarts at pixel (0,0) with a frame_start pulse.
- enable and reset take effect on the edge they are sampled; reset has priority.

Test Plan:
- Params H_ACTIVE=16,H_FP=2,H_SYNC=3,H_BP=3,V_ACTIVE=4,V_FP=1,V_SYNC=2,V_BP=1, release reset -> cycle 1: de=1,x=0,y=0,frame_start=1; de high 16 cycles/line; hsync low at h=18..20; line period 24; vsync low on lines 5..6; frame period 192 cycles; frame_start every 192 cycles.
- mode=1, same params (BAR_W=2) -> line 0 RGB pairs: FFFFFF,FFFF00,00FFFF,00FF00,FF00FF,FF0000,0000FF,000000; RGB=0 at h=16..23.
- mode=0, solid_rgb=24'h123456, switch mode to 2 at mid-frame -> rest of frame stays 123456; next frame checkerboard with CHECK_LOG2=1: (0,0)=000000, (2,0)=FFFFFF, (2,2)=000000.
- Run 257 frames -> frame_count reads 1 after wrap; assert reset mid-line at h=7 -> next cycle all outputs at reset values, hsync=vsync=1; release -> pixel (0,0) with frame_start.
- Drop enable at v=2,h=5 for 10 cycles -> de=0, RGB=0, syncs inactive, frame_count held; re-raise -> x=0,y=0,frame_start=1, frame_count+1.
- mode=5 -> white at x=0, x=15, y=0, y=3; (5,2)=000000; mode=6 -> all active pixels 000000 with de still 1.
